// File: rtl/crypt_fetch_ctrl.sv
// Fetch controller that reads an encrypted instruction word and its key from two ROMs and decrypts it with NROUNDS rotate-xor rounds.
// Optional one-entry last-hit buffer is enabled by defining CRYPT_FETCH_LASTHIT_EN.
module crypt_fetch_ctrl #(
  parameter int XLEN    = 32,
  parameter int AW      = 10,
  parameter int KW      = 4,
  parameter int NROUNDS = 4,
  parameter int ROT     = 3
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            imem_en,
  output logic            kmem_en,
  output logic [AW-1:0]   imem_addr,
  output logic [KW-1:0]   kmem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic [XLEN-1:0] kmem_rdata,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds valid and its payload stable until that edge.

  localparam int CW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_data;
  logic [XLEN-1:0]   r_key;
  logic [CW-1:0]     r_cnt;
  logic              w_accept;
  logic              w_hit;
  logic              w_last_round;
  logic [XLEN-1:0]   w_rot;

  assign w_accept     = req_valid && req_ready;
  assign w_last_round = (r_cnt == CW'(NROUNDS - 1));
  assign w_rot        = (r_data >> ROT) | (r_data << (XLEN - ROT));

`ifdef CRYPT_FETCH_LASTHIT_EN
  logic            r_lh_valid;
  logic [AW-1:0]   r_lh_tag;
  logic [XLEN-1:0] r_lh_data;

  assign w_hit = r_lh_valid && (req_addr == r_lh_tag);

  // Captures every completed response as it is handed to the core.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_lh_valid <= 1'b0;
      r_lh_tag   <= '0;
      r_lh_data  <= '0;
    end else if (r_state == S_DONE && rsp_ready) begin
      r_lh_valid <= 1'b1;
      r_lh_tag   <= r_addr;
      r_lh_data  <= r_data;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= req_addr;
`ifdef CRYPT_FETCH_LASTHIT_EN
            if (w_hit) r_data <= r_lh_data;
`endif
          end
        end
        S_LOAD: begin
          r_data <= imem_rdata;
          r_key  <= kmem_rdata;
          r_cnt  <= '0;
        end
        S_ROUND: begin
          r_data <= w_rot ^ r_key;
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_hit ? S_DONE : S_READ;
      S_READ:  w_next = S_LOAD;
      S_LOAD:  w_next = S_ROUND;
      S_ROUND: if (w_last_round) w_next = S_DONE;
      S_DONE:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request side is closed while reset is held so nothing is accepted on release.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !Rst;
    rsp_valid = (r_state == S_DONE);
    rsp_data  = rsp_valid ? r_data : '0;
    imem_en   = (r_state == S_READ);
    kmem_en   = (r_state == S_READ);
    imem_addr = imem_en ? r_addr : '0;
    kmem_addr = kmem_en ? r_addr[KW-1:0] : '0;
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
  end

endmodule

// File: doc/crypt_fetch_ctrl.md
CRYPT_FETCH_CTRL -- requirements
Module: crypt_fetch_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/key word width.
REQ-002 SHALL have parameter AW, default 10, instruction ROM word-address width.
REQ-003 SHALL have parameter KW, default 4, key ROM word-address width (KW <= AW).
REQ-004 SHALL have parameter NROUNDS, default 4, decrypt rounds (>= 1).
REQ-005 SHALL have parameter ROT, default 3, per-round right-rotate amount (0 < ROT < XLEN).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Rst  input  1  reset; asynchronous, active-high.
REQ-008 req_valid  input  1  core fetch request valid.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 req_addr  input  AW  instruction word address.
REQ-011 rsp_valid  output  1  decrypted instruction valid.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_data  output  XLEN  decrypted instruction.
REQ-014 imem_en / kmem_en  output  1 each  ROM read enables.
REQ-015 imem_addr  output  AW; kmem_addr  output  KW  ROM addresses.
REQ-016 imem_rdata / kmem_rdata  input  XLEN each  ROM data, valid the cycle after the enable (synchronous read).
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement FSM IDLE, READ, LOAD, ROUND, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid && req_ready; req_addr SHALL then be registered.
REQ-020 IDLE -> READ on transfer; otherwise stay.
REQ-021 READ: imem_en = kmem_en = 1 for exactly one cycle, imem_addr = registered addr, kmem_addr = registered addr[KW-1:0]; -> LOAD.
REQ-022 LOAD: data register <= imem_rdata, key register <= kmem_rdata, round counter <= 0; -> ROUND.
REQ-023 ROUND: each cycle d <= rotr(d, ROT) XOR key, modulo-XLEN rotate, no width growth; counter increments; -> DONE after the NROUNDS-th round.
REQ-024 DONE: rsp_valid = 1, rsp_data = d; -> IDLE on rsp_ready, else hold with rsp_valid and rsp_data stable.
REQ-025 Miss latency SHALL be 3 + NROUNDS cycles from accept edge to first rsp_valid cycle (7 at default).
REQ-026 ROM enables SHALL be 0 in every state except READ; imem_addr/kmem_addr SHALL be 0 when not enabled.
REQ-027 rsp_data SHALL be 0 whenever rsp_valid = 0.
REQ-028 req_valid asserted outside IDLE SHALL be ignored and not queued; the core holds it until req_ready.
REQ-029 The cycle rsp_valid && rsp_ready leaves DONE, req_ready SHALL still be 0; the next accept is the following cycle.

Reset
REQ-030 Rst asserted at any time, including mid-ROUND or in DONE, SHALL immediately force IDLE and set all registers to 0.
REQ-031 Reset output values SHALL be: req_ready 0 while Rst high and 1 after release; rsp_valid 0; rsp_data 0; imem_en 0; kmem_en 0; busy 0.
REQ-032 An in-flight request interrupted by reset SHALL be discarded without producing a response.

Configuration
REQ-033 Macro CRYPT_FETCH_LASTHIT_EN defined: one-entry last-hit buffer (tag, data, valid), updated on every DONE exit; an accept with valid && req_addr == tag SHALL go IDLE -> DONE with the buffered data (1-cycle latency) and no ROM access; reset SHALL clear valid.
REQ-034 Macro undefined: no buffer logic; every request takes the full miss path of REQ-025.

Verification
REQ-035 Reset release, req at addr 0x000 with imem = 0x00000008, key = 0 -> rsp_valid on cycle 7, rsp_data 0x00800000.
REQ-036 imem = 0x00000000, key = 0xFFFFFFFF, NROUNDS = 4 -> rsp_data 0x00000000; with NROUNDS = 3 -> 0xFFFFFFFF.
REQ-037 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid and rsp_data stable, no ROM enables, req_ready 0.
REQ-038 Rst pulse during the second ROUND cycle -> next cycle IDLE, outputs 0, no rsp_valid for the aborted request.
REQ-039 With CRYPT_FETCH_LASTHIT_EN, the same address twice -> second rsp_valid 1 cycle after accept, imem_en never asserted; a different address -> 7-cycle miss.
REQ-040 Back-to-back requests with rsp_ready tied 1 -> one accept every 8 cycles, no lost or duplicated responses.
